// File: rtl/ls163_counter_chain.sv
// ls163_counter_chain: presettable synchronous binary counter made of STAGES
// cascaded 74LS163-style 4-bit sections with a lookahead ripple-carry chain.
// Clear and load are shared by every section. ENP goes to every section.
// ENT enters section 0 only, and each section's RCO enables the next section.

// One 74LS163 section.
// Priority: clear, then load, then count.
// RCO is combinational and ignores ENP, matching the TTL part.
module ls163_section (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       load_n,
    input  logic       enp,
    input  logic       ent,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       rco
);

    // Synchronous clear/load/count register; clear overrides everything.
    always_ff @(posedge clk) begin
        if (!clr_n)
            q <= 4'h0;
        else if (!load_n)
            q <= d;
        else if (enp && ent)
            q <= q + 4'h1;
    end

    assign rco = ent & (q == 4'hF);

endmodule

module ls163_counter_chain #(
    parameter int STAGES = 2,
    parameter int W      = 4 * STAGES
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              load_n,
    input  logic              enp,
    input  logic              ent,
    input  logic [W-1:0]      d,
    output logic [W-1:0]      q,
    output logic [STAGES-1:0] stage_rco,
    output logic              rco
);

    // ent_chain[k] is the ENT seen by section k.
    // Section k's ENT is the RCO of section k-1, so a section only advances
    // while every lower section sits at 4'hF.
    logic [STAGES:0] ent_chain;

    assign ent_chain[0] = ent;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_sec
            ls163_section u_sec (
                .clk    (clk),
                .clr_n  (clr_n),
                .load_n (load_n),
                .enp    (enp),
                .ent    (ent_chain[k]),
                .d      (d[4*k +: 4]),
                .q      (q[4*k +: 4]),
                .rco    (stage_rco[k])
            );
            assign ent_chain[k+1] = stage_rco[k];
        end
    endgenerate

    assign rco = stage_rco[STAGES-1];

endmodule

// File: tb/tb_ls163_counter_chain.sv
// Directed bench for ls163_counter_chain.
// A flat W-bit reference model predicts q and the carry outputs. Each
// prediction is queued when stimulus is driven and compared after the edge.
module tb_ls163_counter_chain;

    localparam int STAGES = 2;
    localparam int W      = 4 * STAGES;

    logic              clk = 1'b0;
    logic              clr_n = 1'b1;
    logic              load_n = 1'b1;
    logic              enp = 1'b0;
    logic              ent = 1'b0;
    logic [W-1:0]      d = '0;
    logic [W-1:0]      q;
    logic [STAGES-1:0] stage_rco;
    logic              rco;

    ls163_counter_chain #(.STAGES(STAGES)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .load_n    (load_n),
        .enp       (enp),
        .ent       (ent),
        .d         (d),
        .q         (q),
        .stage_rco (stage_rco),
        .rco       (rco)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             tag;
        logic [W-1:0]      q;
        logic [STAGES-1:0] srco;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] mq = '0;
    int           compared = 0;
    int           mismatched = 0;

    // Section k carries when ENT is high and all bits up to its top bit are ones.
    function automatic logic [STAGES-1:0] exp_srco(input logic [W-1:0] qv, input logic t);
        logic [STAGES-1:0] r;
        logic [W-1:0]      m;
        r = '0;
        for (int k = 0; k < STAGES; k++) begin
            m    = W'((64'd1 << (4 * k + 4)) - 64'd1);
            r[k] = t && ((qv & m) == m);
        end
        return r;
    endfunction

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL scoreboard: queue empty, want one entry");
            return;
        end
        e = sb.pop_front();
        compared += 3;
        assert (q === e.q) else begin
            mismatched++;
            $error("FAIL %s q: got %h want %h", e.tag, q, e.q);
        end
        assert (stage_rco === e.srco) else begin
            mismatched++;
            $error("FAIL %s stage_rco: got %b want %b", e.tag, stage_rco, e.srco);
        end
        assert (rco === e.srco[STAGES-1]) else begin
            mismatched++;
            $error("FAIL %s rco: got %b want %b", e.tag, rco, e.srco[STAGES-1]);
        end
    endtask

    // Drive one edge's controls, predict the result, then check after the edge.
    task automatic drive(input string tag, input logic c, input logic l,
                         input logic p, input logic t, input logic [W-1:0] dv);
        clr_n  = c;
        load_n = l;
        enp    = p;
        ent    = t;
        d      = dv;
        if (!c)
            mq = '0;
        else if (!l)
            mq = dv;
        else if (p && t)
            mq = mq + 1'b1;
        sb.push_back('{tag, mq, exp_srco(mq, t)});
        @(posedge clk);
        #1;
        check();
    endtask

    // Change ENT between edges and check the combinational carry outputs at once.
    task automatic set_ent_now(input string tag, input logic t);
        ent = t;
        #1;
        sb.push_back('{tag, mq, exp_srco(mq, t)});
        check();
    endtask

    initial begin
        // Clear wins over load and the enables.
        drive("clr0", 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
        drive("clr1", 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);

        // Load then wrap through FF.
        drive("ldFE",  1'b1, 1'b0, 1'b1, 1'b1, 8'hFE);
        drive("wrFF",  1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        drive("wr00",  1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        drive("wr01",  1'b1, 1'b1, 1'b1, 1'b1, 8'h00);

        // Section carry: 0F -> 10.
        drive("ld0F",  1'b1, 1'b0, 1'b0, 1'b1, 8'h0F);
        drive("cy10",  1'b1, 1'b1, 1'b1, 1'b1, 8'h00);

        // ENP low holds at FF with rco high; dropping ENT kills rco immediately.
        drive("ldFF",  1'b1, 1'b0, 1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 4; i++)
            drive("holdP", 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        set_ent_now("entlo", 1'b0);
        drive("holdT", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        set_ent_now("enthi", 1'b1);

        // Load beats counting.
        drive("ld36",  1'b1, 1'b0, 1'b0, 1'b0, 8'h36);
        drive("cy37",  1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        drive("ldpri", 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C);

        // Free-run from zero to 5A, then clear with load, then resume.
        drive("clr2",  1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8'h5A; i++)
            drive("run", 1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
        drive("clrmid", 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
        drive("res01",  1'b1, 1'b1, 1'b1, 1'b1, 8'hA5);
        drive("res02",  1'b1, 1'b1, 1'b1, 1'b1, 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
